// File: rtl/music_view_sequencer.sv
// music_view_sequencer: beat-paced four-track note scroller fed by a valid/ready note source.
module music_view_sequencer #(
    parameter int unsigned BEAT_DIV = 50_000_000
) (
    input  logic       EGO1_Clock,
    input  logic       reset,
    input  logic       play,
    input  logic       step,
    input  logic       note_valid,
    input  logic [5:0] note_data,
    input  logic       note_last,
    output logic       note_ready,
    output logic [5:0] track0,
    output logic [5:0] track1,
    output logic [5:0] track2,
    output logic [5:0] track3,
    output logic       beat_tick,
    output logic [1:0] state,
    output logic       underrun
);
    typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, WAIT = 2'b10, DRAIN = 2'b11} state_t;
    localparam logic [31:0] LAST = 32'(BEAT_DIV - 1);
    state_t      st;
    logic [31:0] cnt;
    logic [2:0]  dcnt;
    logic        first;
    logic        beating;
    assign state      = st;
    assign note_ready = st == FETCH;
    assign beating    = st == WAIT || st == DRAIN;
    assign beat_tick  = beating && (play ? cnt == LAST : step);
    always_ff @(posedge EGO1_Clock) begin
        if (reset) begin
            st       <= IDLE;
            cnt      <= '0;
            dcnt     <= '0;
            first    <= 1'b0;
            underrun <= 1'b0;
            track0   <= '0;
            track1   <= '0;
            track2   <= '0;
            track3   <= '0;
        end else begin
            first <= st == WAIT && beat_tick;
            if (beating)
                cnt <= beat_tick ? '0 : play ? cnt + 32'd1 : cnt;
            case (st)
                IDLE: st <= play ? FETCH : IDLE;
                FETCH: begin
                    if (first && !note_valid)
                        underrun <= 1'b1;
                    if (note_valid) begin
                        {track0, track1, track2, track3} <= {track1, track2, track3, note_data};
                        cnt  <= '0;
                        dcnt <= '0;
                        st   <= note_last ? DRAIN : WAIT;
                    end
                end
                WAIT: st <= beat_tick ? FETCH : WAIT;
                DRAIN: begin
                    if (beat_tick) begin
                        {track0, track1, track2, track3} <= {track1, track2, track3, 6'd0};
                        dcnt <= dcnt == 3'd3 ? 3'd0 : dcnt + 3'd1;
                        st   <= dcnt == 3'd3 ? IDLE : DRAIN;
                    end
                end
            endcase
        end
    end
endmodule
